// File: rtl/mem_stage_pkg.sv
// Shared bus widths, bus layouts, load-op encodings and exception bit positions
// for the MIPS memory stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD   = 99;
  localparam int MS_TO_WS_BUS_WD   = 94;
  localparam int STALL_MS_BUS_WD   = 11;
  localparam int FORWARD_MS_BUS_WD = 33;

  typedef enum logic [2:0] {
    LOAD_OP_LB   = 3'd0,
    LOAD_OP_LBU  = 3'd1,
    LOAD_OP_LH   = 3'd2,
    LOAD_OP_LHU  = 3'd3,
    LOAD_OP_LW   = 3'd4,
    LOAD_OP_LWL  = 3'd5,
    LOAD_OP_LWR  = 3'd6,
    LOAD_OP_NONE = 3'd7
  } load_op_e;

  // Bit positions inside the 8-bit exc_type vector carried down the pipe.
  localparam int EXC_TYPE_INT   = 0;
  localparam int EXC_TYPE_ADEL  = 1;
  localparam int EXC_TYPE_ADES  = 2;
  localparam int EXC_TYPE_OV    = 3;
  localparam int EXC_TYPE_SYS   = 4;
  localparam int EXC_TYPE_BP    = 5;
  localparam int EXC_TYPE_RI    = 6;
  localparam int EXC_TYPE_ADEIF = 7;

  typedef struct packed {
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        req_sent;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // IDLE: nothing owed; WAIT: response outstanding; HELD: response parked in buffer.
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HELD = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half/word out of the SRAM word,
// extends it, and produces the per-byte GPR write mask for LWL/LWR merges.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o,
  output logic [3:0]  we_mask_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  lwl_shamt;
  logic [4:0]  lwr_shamt;

  assign sel_byte  = 8'(rdata_i >> {addr_i, 3'b000});
  assign sel_half  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  // 3 - a equals ~a for a two-bit address.
  assign lwl_shamt = {~addr_i, 3'b000};
  assign lwr_shamt = {addr_i, 3'b000};

  always_comb begin
    result_o  = rdata_i;
    we_mask_o = 4'b1111;
    case (load_op_e'(load_op_i))
      LOAD_OP_LB:  result_o = {{24{sel_byte[7]}}, sel_byte};
      LOAD_OP_LBU: result_o = {24'b0, sel_byte};
      LOAD_OP_LH:  result_o = {{16{sel_half[15]}}, sel_half};
      LOAD_OP_LHU: result_o = {16'b0, sel_half};
      LOAD_OP_LW:  result_o = rdata_i;
      LOAD_OP_LWL: begin
        result_o  = rdata_i << lwl_shamt;
        we_mask_o = 4'b1111 << ~addr_i;
      end
      LOAD_OP_LWR: begin
        result_o  = rdata_i >> lwr_shamt;
        we_mask_o = 4'b1111 >> addr_i;
      end
      default: begin
        result_o  = rdata_i;
        we_mask_o = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: holds one instruction, waits for its data-SRAM response,
// aligns load data, and feeds forwarding/hazard information back to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [STALL_MS_BUS_WD-1:0] stall_ms_bus,
  output logic [FORWARD_MS_BUS_WD-1:0] forward_ms_bus,
  output logic                       ms_exc_eret,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       data_sram_data_ok
);

  es_to_ms_t   in_bus;
  es_to_ms_t   ms_bus_q;
  es_to_ms_t   ms_bus_d;
  logic        ms_valid_q;
  logic        ms_valid_d;
  ms_state_e   state_q;
  logic        cancel_pending_q;
  logic [31:0] rdata_buf_q;

  logic        rdata_buf_valid;
  logic        need_data;
  logic        data_ok_live;
  logic        ready_go;
  logic        accept;
  logic        in_need_data;

  logic [31:0] align_rdata;
  logic [31:0] align_result;
  logic [3:0]  align_we_mask;
  logic [31:0] ms_result;
  logic [3:0]  ms_gr_we;
  logic [3:0]  gr_we_vis;
  logic [4:0]  dest_vis;
  logic        load_pending;
  ms_to_ws_t   ms_out;

  assign in_bus          = es_to_ms_t'(es_to_ms_bus);
  assign rdata_buf_valid = (state_q == MS_HELD);
  assign need_data       = ms_valid_q & ms_bus_q.res_from_mem & ms_bus_q.req_sent & ~ms_bus_q.exc;
  // A response arriving while a cancel is pending belongs to a flushed load.
  assign data_ok_live    = data_sram_data_ok & ~cancel_pending_q;
  assign ready_go        = ~need_data | rdata_buf_valid | data_ok_live;
  assign ms_allowin      = ~ms_valid_q | (ready_go & ws_allowin);
  assign ms_to_ws_valid  = ms_valid_q & ready_go;
  assign accept          = es_to_ms_valid & ms_allowin;
  assign in_need_data    = in_bus.res_from_mem & in_bus.req_sent & ~in_bus.exc;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
  end

  assign ms_bus_d = accept ? in_bus : ms_bus_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      ms_bus_q   <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      ms_bus_q   <= ms_bus_d;
    end
  end

  // Response tracking. A flush during WAIT without a same-cycle response leaves
  // one reply in flight, which cancel_pending swallows when it finally shows up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= MS_IDLE;
      cancel_pending_q <= 1'b0;
      rdata_buf_q      <= 32'b0;
    end else begin
      if (cancel_pending_q && data_sram_data_ok) begin
        cancel_pending_q <= 1'b0;
      end
      if (flush && (state_q == MS_WAIT) && !data_ok_live) begin
        cancel_pending_q <= 1'b1;
      end

      if (flush) begin
        state_q     <= MS_IDLE;
        rdata_buf_q <= 32'b0;
      end else if (ms_allowin) begin
        state_q     <= (accept && in_need_data) ? MS_WAIT : MS_IDLE;
        rdata_buf_q <= 32'b0;
      end else if ((state_q == MS_WAIT) && data_ok_live) begin
        state_q     <= MS_HELD;
        rdata_buf_q <= data_sram_rdata;
      end
    end
  end

  assign align_rdata = rdata_buf_valid ? rdata_buf_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .load_op_i (ms_bus_q.load_op),
    .addr_i    (ms_bus_q.alu_result[1:0]),
    .rdata_i   (align_rdata),
    .result_o  (align_result),
    .we_mask_o (align_we_mask)
  );

  always_comb begin
    ms_result = ms_bus_q.alu_result;
    ms_gr_we  = ms_bus_q.gr_we;
    if (ms_bus_q.res_from_mem) begin
      ms_result = align_result;
      ms_gr_we  = ms_bus_q.gr_we & align_we_mask;
    end
    if (ms_bus_q.exc) begin
      ms_gr_we = 4'b0000;
    end
  end

  always_comb begin
    ms_out              = '0;
    ms_out.bd           = ms_bus_q.bd;
    ms_out.exc          = ms_bus_q.exc;
    ms_out.exc_type     = ms_bus_q.exc_type;
    ms_out.eret         = ms_bus_q.eret;
    ms_out.cp0_wen      = ms_bus_q.cp0_wen;
    ms_out.res_from_cp0 = ms_bus_q.res_from_cp0;
    ms_out.cp0_addr     = ms_bus_q.cp0_addr;
    ms_out.gr_we        = ms_gr_we;
    ms_out.dest         = ms_bus_q.dest;
    ms_out.result       = ms_result;
    ms_out.pc           = ms_bus_q.pc;
  end

  assign ms_to_ws_bus = ms_out;

  assign gr_we_vis    = ms_valid_q ? ms_gr_we : 4'b0000;
  assign dest_vis     = ms_valid_q ? ms_bus_q.dest : 5'b00000;
  assign load_pending = ms_valid_q & ms_bus_q.res_from_mem & ~ready_go;

  assign stall_ms_bus   = {|gr_we_vis, gr_we_vis, dest_vis, load_pending};
  assign forward_ms_bus = {ms_to_ws_valid, ms_to_ws_valid ? ms_result : 32'b0};
  assign ms_exc_eret    = ms_valid_q & (ms_bus_q.exc | ms_bus_q.eret);

endmodule
